// File: rtl/vx_dcache_req_buffer_pkg.sv
// vx_dcache_req_buffer_pkg: shared entry type and helpers for the dcache request buffer
// Contents: req_entry_t (default-width lane entry), pending_width(), popcount()
package vx_dcache_req_buffer_pkg;
  localparam int REQ_ADDR_WIDTH = 30;
  localparam int REQ_DATA_WIDTH = 32;
  localparam int REQ_TAG_WIDTH = 8;
  typedef struct packed {
    logic rw;
    logic [REQ_DATA_WIDTH/8-1:0] byteen;
    logic [REQ_ADDR_WIDTH-1:0] addr;
    logic [REQ_DATA_WIDTH-1:0] data;
    logic [REQ_TAG_WIDTH-1:0] tag;
  } req_entry_t;
  function automatic int pending_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction
  function automatic logic [6:0] popcount(input logic [63:0] v);
    popcount = '0;
    for (int i = 0; i < 64; i++) popcount += 7'(v[i]);
  endfunction
endpackage

// File: rtl/vx_lane_fifo.sv
// vx_lane_fifo: per-lane DEPTH-entry request FIFO with registered storage
// Ports: clk, reset (async active-low), push/din, pop/dout (head entry), count, full, empty
module vx_lane_fifo import vx_dcache_req_buffer_pkg::*; #(
  parameter int DEPTH = 4,
  parameter type T = req_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  assign dout  = mem[rd_ptr];
  assign full  = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/vx_dcache_req_buffer.sv
// vx_dcache_req_buffer: elastic LSU-to-dcache request buffer with per-lane FIFOs and read-credit throttling
// Ports: clk, reset (async active-low); in_* warp request with in_ready; dc_req_* per-lane head-of-FIFO
// requests with dc_req_ready; dc_rsp_valid/dc_rsp_tmask returns read lanes (dc_rsp_ready tied 1); busy.
// Optional: VX_DCACHE_REQ_BUFFER_PERF_EN adds perf_stall_cycles (cycles with in_valid && !in_ready).
module vx_dcache_req_buffer import vx_dcache_req_buffer_pkg::*; #(
  parameter int NUM_REQS    = 4,
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = 30,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  input  logic [NUM_REQS-1:0]                  in_tmask,
  input  logic                                 in_rw,
  input  logic [NUM_REQS*DATA_WIDTH/8-1:0]     in_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]       in_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]       in_data,
  input  logic [TAG_WIDTH-1:0]                 in_tag,
  output logic                                 in_ready,
  output logic [NUM_REQS-1:0]                  dc_req_valid,
  output logic [NUM_REQS-1:0]                  dc_req_rw,
  output logic [NUM_REQS*DATA_WIDTH/8-1:0]     dc_req_byteen,
  output logic [NUM_REQS*ADDR_WIDTH-1:0]       dc_req_addr,
  output logic [NUM_REQS*DATA_WIDTH-1:0]       dc_req_data,
  output logic [NUM_REQS*TAG_WIDTH-1:0]        dc_req_tag,
  input  logic [NUM_REQS-1:0]                  dc_req_ready,
  input  logic                                 dc_rsp_valid,
  input  logic [NUM_REQS-1:0]                  dc_rsp_tmask,
  output logic                                 dc_rsp_ready,
  output logic                                 busy
`ifdef VX_DCACHE_REQ_BUFFER_PERF_EN
  ,
  output logic [63:0]                          perf_stall_cycles
`endif
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int PW = pending_width(MAX_PENDING);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic rw;
    logic [BW-1:0] byteen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;
  logic [NUM_REQS-1:0] full, empty, occupied;
  logic [PW-1:0] pending;
  logic [PW:0] inc_sum, rsp_dec;
  logic [6:0] in_cnt, rsp_cnt;
  logic accept;
  assign in_cnt  = popcount(64'(in_tmask));
  assign rsp_cnt = popcount(64'(dc_rsp_tmask));
  // Credit check uses registered pending only, so a same-cycle response never opens the gate early.
  assign in_ready = ~|(in_tmask & full) && (in_rw || 32'(pending) + 32'(in_cnt) <= MAX_PENDING);
  assign accept = in_valid && in_ready;
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
    entry_t din, dout;
    logic [CW-1:0] count;
    assign din = {in_rw, in_byteen[i*BW +: BW], in_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                  in_data[i*DATA_WIDTH +: DATA_WIDTH], in_tag};
    vx_lane_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept && in_tmask[i]),
      .din   (din),
      .pop   (dc_req_valid[i] && dc_req_ready[i]),
      .dout  (dout),
      .count (count),
      .full  (full[i]),
      .empty (empty[i])
    );
    assign occupied[i] = |count;
    assign dc_req_valid[i] = !empty[i];
    assign dc_req_rw[i] = dout.rw;
    assign dc_req_byteen[i*BW +: BW] = dout.byteen;
    assign dc_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = dout.addr;
    assign dc_req_data[i*DATA_WIDTH +: DATA_WIDTH] = dout.data;
    assign dc_req_tag[i*TAG_WIDTH +: TAG_WIDTH] = dout.tag;
  end
  // One extra bit on the intermediate sum keeps load increments from wrapping before the decrement.
  assign inc_sum = {1'b0, pending} + (accept && !in_rw ? (PW+1)'(in_cnt) : '0);
  assign rsp_dec = dc_rsp_valid ? (PW+1)'(rsp_cnt) : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) pending <= '0;
    else pending <= rsp_dec > inc_sum ? '0 : PW'(inc_sum - rsp_dec);
  assert property (@(posedge clk) disable iff (!reset) dc_rsp_valid |-> rsp_dec <= inc_sum);
  assign dc_rsp_ready = 1'b1;
  assign busy = |occupied || pending != '0;
`ifdef VX_DCACHE_REQ_BUFFER_PERF_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) perf_stall_cycles <= '0;
    else if (in_valid && !in_ready) perf_stall_cycles <= perf_stall_cycles + 1'b1;
`endif
endmodule
